// File: rtl/imem_loader.sv
// Byte-stream program loader: packs a length-prefixed, XOR-checksummed image into 32-bit
// little-endian words for the instruction memory and holds the core until a good load completes.
module imem_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_wren,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_data,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int              TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0]     DEPTH  = 17'(1) << ADDR_WIDTH;
  localparam logic [TW-1:0]   TLIMIT = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t          state;
  logic [7:0]      len_lo;
  logic [15:0]     word_total;
  logic [15:0]     word_cnt;
  logic [1:0]      idx;
  logic [23:0]     word_buf;
  logic [7:0]      csum;
  logic [TW-1:0]   idle_cnt;
  logic            accept;
  logic [15:0]     word_next;

  assign accept    = byte_valid & byte_ready;
  assign word_next = word_cnt + 16'd1;

  // NOTE: every register here is state, so all assignments are non-blocking; blocking
  // assignments would make later reads in this block see same-cycle values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      byte_ready <= 1'b0;
      imem_wren  <= 1'b0;
      imem_addr  <= '0;
      imem_data  <= '0;
      core_hold  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      len_lo     <= '0;
      word_total <= '0;
      word_cnt   <= '0;
      idx        <= '0;
      word_buf   <= '0;
      csum       <= '0;
      idle_cnt   <= '0;
    end else begin
      imem_wren <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (load_start) begin
            state      <= S_LEN_LO;
            byte_ready <= 1'b1;
            core_hold  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            word_cnt   <= '0;
            idx        <= '0;
            csum       <= '0;
            idle_cnt   <= '0;
          end
        end

        S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: begin
          if (accept) begin
            idle_cnt <= '0;
            case (state)
              S_LEN_LO: begin
                len_lo <= byte_data;
                state  <= S_LEN_HI;
              end
              S_LEN_HI: begin
                word_total <= {byte_data, len_lo};
                if ({1'b0, byte_data, len_lo} > DEPTH) begin
                  state      <= S_ERROR;
                  byte_ready <= 1'b0;
                  load_error <= 1'b1;
                end else if ({byte_data, len_lo} == 16'd0) begin
                  state <= S_CSUM;
                end else begin
                  state <= S_DATA;
                end
              end
              S_DATA: begin
                csum <= csum ^ byte_data;
                idx  <= idx + 2'd1;
                if (idx == 2'd3) begin
                  // Word complete: the write lands while the next group's first byte arrives.
                  imem_wren <= 1'b1;
                  imem_addr <= word_cnt[ADDR_WIDTH-1:0];
                  imem_data <= {byte_data, word_buf};
                  word_cnt  <= word_next;
                  if (word_next == word_total) state <= S_CSUM;
                end else begin
                  word_buf[{idx, 3'b000} +: 8] <= byte_data;
                end
              end
              S_CSUM: begin
                byte_ready <= 1'b0;
                if (byte_data == csum) begin
                  state     <= S_DONE;
                  load_done <= 1'b1;
                  core_hold <= 1'b0;
                end else begin
                  state      <= S_ERROR;
                  load_error <= 1'b1;
                end
              end
              default: ;
            endcase
          end else if (idle_cnt == TLIMIT) begin
            state      <= S_ERROR;
            byte_ready <= 1'b0;
            load_error <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        default: begin
          state      <= S_IDLE;
          byte_ready <= 1'b0;
          core_hold  <= 1'b1;
          load_done  <= 1'b0;
          load_error <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected memory writes are queued as bytes are driven
// and matched against each imem_wren; status outputs are checked after each scenario.
module tb_imem_loader;

  localparam int AW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_wren;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          core_hold;
  logic          load_done;
  logic          load_error;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [39:0]   exp_q[$];
  logic [31:0]   img [4];
  bit            bb_active = 1'b0;
  int            ready_drops = 0;

  imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_wren  (imem_wren),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .core_hold  (core_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && imem_wren) begin
      if (exp_q.size() == 0) check("wren_unexpected", 64'd1, 64'd0);
      else check("wren", {24'd0, imem_addr, imem_data}, {24'd0, exp_q.pop_front()});
    end
    if (bb_active && !byte_ready) ready_drops++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit hold_valid);
    int waited = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!byte_ready) check("ready_wait", 64'd0, 64'd1);
    step();
    if (!hold_valid) byte_valid = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("start_status", {60'd0, byte_ready, load_done, load_error, core_hold}, 64'b1001);
  endtask

  task automatic send_word(input logic [31:0] w, input int addr, input bit hv);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back({8'(addr), w});
      send_byte(w[8*i +: 8], hv);
    end
  endtask

  task automatic run_load(input int n, input logic [7:0] csum_flip, input bit hv);
    logic [7:0] x = 8'h00;
    start_load();
    send_byte(8'(n), hv);
    bb_active = hv;
    send_byte(8'(n >> 8), hv);
    for (int i = 0; i < n; i++) begin
      send_word(img[i], i, hv);
      x = x ^ img[i][7:0] ^ img[i][15:8] ^ img[i][23:16] ^ img[i][31:24];
    end
    send_byte(x ^ csum_flip, 1'b0);
    bb_active = 1'b0;
  endtask

  // {load_done, load_error, core_hold, byte_ready}
  function automatic logic [63:0] status();
    return {60'd0, load_done, load_error, core_hold, byte_ready};
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {19'd0, byte_ready, imem_wren, imem_addr, imem_data, core_hold, load_done, load_error},
          {19'd0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
    step();

    // Single word, good checksum.
    img[0] = 32'h0000_0013;
    run_load(1, 8'h00, 1'b0);
    check("one_word_done", status(), 64'b1000);

    // Three words back to back with valid held high.
    img[0] = 32'hDEAD_BEEF;
    img[1] = 32'h0102_0304;
    img[2] = 32'hA5C3_0F70;
    ready_drops = 0;
    run_load(3, 8'h00, 1'b1);
    check("b2b_done", status(), 64'b1000);
    check("b2b_ready_drops", 64'(ready_drops), 64'd0);

    // Bad checksum: words still written, error latched, core held.
    img[0] = 32'h1122_3344;
    img[1] = 32'h5566_7788;
    run_load(2, 8'h01, 1'b0);
    check("bad_csum_status", status(), 64'b0110);

    // Zero-length image.
    run_load(0, 8'h00, 1'b0);
    check("n0_done", status(), 64'b1000);

    // Length one beyond the memory depth.
    start_load();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    check("n_too_big", status(), 64'b0110);

    // Stall of TO-1 cycles mid-word is tolerated.
    start_load();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    repeat (TO - 1) step();
    check("stall15_no_error", status(), 64'b0011);
    send_byte(8'h34, 1'b0);
    exp_q.push_back({8'h00, 32'h1234_5678});
    send_byte(8'h12, 1'b0);
    send_byte(8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12, 1'b0);
    check("stall15_done", status(), 64'b1000);

    // Stall of TO cycles mid-word times out.
    start_load();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    repeat (TO - 1) step();
    check("stall16_before", status(), 64'b0011);
    step();
    check("stall16_error", status(), 64'b0110);

    // Async reset between bytes 2 and 3 of the second word.
    start_load();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(32'hCAFE_F00D, 0, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midload_reset",
          {19'd0, byte_ready, imem_wren, imem_addr, imem_data, core_hold, load_done, load_error},
          {19'd0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0});
    #3 rst = 1'b0;
    step();
    img[0] = 32'h8765_4321;
    img[1] = 32'h0BAD_F00D;
    run_load(2, 8'h00, 1'b0);
    check("after_reset_done", status(), 64'b1000);

    repeat (3) step();
    check("pending_writes", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
